ha_bist: RTL and testbench

Hardware self-test engine for the half-adder datapath. It drives {a,b} through every input combination and samples the sum/carry response after a configurable latency. It compares each response against the half-adder truth table and reports pass/fail, an error count and the first failing vector. It sits opposite the adder as the response-checking end of the same a/b → sum/carry interface, so the adder can be self-checked on silicon or FPGA without a simulator bench.

---
 rtl/ha_bist.sv | 130 +++++++++++++
 tb/tb_ha_bist.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ha_bist.sv
// rtl/ha_bist.sv - self-test engine that sweeps a half adder and checks its responses
module ha_bist #(
   parameter int LATENCY = 0,
   parameter int LOOPS   = 1,
   parameter int ERR_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a_out,
   output logic             b_out,
   input  logic             sum_in,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             fail_valid,
   output logic [1:0]       fail_vec
);

   localparam int LAT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
   localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
   localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATENCY);
   localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_vec;
   logic [LAT_W-1:0]  r_wait;
   logic [LOOP_W-1:0] r_loop;
   logic [ERR_W-1:0]  r_err;
   logic              r_pass;
   logic              r_fail_valid;
   logic [1:0]        r_fail_vec;
   logic              w_start_run;
   logic              w_sample;
   logic              w_last;
   logic              w_mismatch;
   logic              w_busy;
   logic              w_done;

   // The vector register doubles as the stimulus; it is zero whenever no run is active.
   assign a_out      = r_vec[1];
   assign b_out      = r_vec[0];
   assign busy       = w_busy;
   assign done       = w_done;
   assign pass       = r_pass;
   assign err_count  = r_err;
   assign fail_valid = r_fail_valid;
   assign fail_vec   = r_fail_vec;

   // Compare against the half-adder truth table of the vector currently driven.
   assign w_mismatch = (sum_in != (r_vec[1] ^ r_vec[0])) || (carry_in != (r_vec[1] & r_vec[0]));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next state, sample strobe and status outputs.
   always_comb begin
      w_next      = r_state;
      w_start_run = 1'b0;
      w_sample    = 1'b0;
      w_last      = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next      = S_RUN;
               w_start_run = 1'b1;
            end
         end
         S_RUN: begin
            w_busy   = 1'b1;
            w_sample = (r_wait == LAT_LAST);
            w_last   = w_sample && (r_vec == 2'b11) && (r_loop == LOOP_LAST);
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Vector sequencing, latency wait and result bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vec        <= 2'b00;
         r_wait       <= '0;
         r_loop       <= '0;
         r_err        <= '0;
         r_pass       <= 1'b0;
         r_fail_valid <= 1'b0;
         r_fail_vec   <= 2'b00;
      end else if (w_start_run) begin
         r_vec        <= 2'b00;
         r_wait       <= '0;
         r_loop       <= '0;
         r_err        <= '0;
         r_pass       <= 1'b0;
         r_fail_valid <= 1'b0;
         r_fail_vec   <= 2'b00;
      end else if (w_sample) begin
         r_wait <= '0;
         // Wraps 11 -> 00, which also parks the stimulus at zero after the final vector.
         r_vec  <= r_vec + 2'd1;
         if (r_vec == 2'b11) r_loop <= r_loop + LOOP_W'(1);
         if (w_mismatch) begin
            if (r_err != '1) r_err <= r_err + ERR_W'(1);
            if (!r_fail_valid) begin
               r_fail_valid <= 1'b1;
               r_fail_vec   <= r_vec;
            end
         end
         // Final verdict must include the sample taken on this very edge.
         if (w_last) r_pass <= (r_err == '0) && !w_mismatch;
      end else if (r_state == S_RUN) begin
         r_wait <= r_wait + LAT_W'(1);
      end
   end

endmodule

// File: tb/tb_ha_bist.sv
// tb/tb_ha_bist.sv - directed self-checking bench for ha_bist
module tb_ha_bist;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start_v;
   logic [2:0] a_v, b_v, busy_v, done_v, pass_v, fv_v;
   logic [7:0] err0, err1;
   logic [1:0] err2;
   logic [1:0] fvec0, fvec1, fvec2;
   logic       sum0, carry0, sum1, carry1, sum2, carry2;
   logic       rs0, rc0, rs1, rc1;
   logic [1:0] mode0;
   int         n_pass = 0;
   int         n_total = 0;

   always #5 clk = ~clk;

   // u0: LATENCY=0, LOOPS=1, adder behaviour selected by mode0
   ha_bist #(.LATENCY(0), .LOOPS(1), .ERR_W(8)) u0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .a_out(a_v[0]), .b_out(b_v[0]),
      .sum_in(sum0), .carry_in(carry0), .busy(busy_v[0]), .done(done_v[0]),
      .pass(pass_v[0]), .err_count(err0), .fail_valid(fv_v[0]), .fail_vec(fvec0));

   // u1: LATENCY=1 against a one-cycle registered adder
   ha_bist #(.LATENCY(1), .LOOPS(1), .ERR_W(8)) u1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .a_out(a_v[1]), .b_out(b_v[1]),
      .sum_in(sum1), .carry_in(carry1), .busy(busy_v[1]), .done(done_v[1]),
      .pass(pass_v[1]), .err_count(err1), .fail_valid(fv_v[1]), .fail_vec(fvec1));

   // u2: ERR_W=2, LOOPS=2 against an adder with both outputs inverted
   ha_bist #(.LATENCY(0), .LOOPS(2), .ERR_W(2)) u2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .a_out(a_v[2]), .b_out(b_v[2]),
      .sum_in(sum2), .carry_in(carry2), .busy(busy_v[2]), .done(done_v[2]),
      .pass(pass_v[2]), .err_count(err2), .fail_valid(fv_v[2]), .fail_vec(fvec2));

   // Registered adder models
   always_ff @(posedge clk) begin
      rs0 <= a_v[0] ^ b_v[0];
      rc0 <= a_v[0] & b_v[0];
      rs1 <= a_v[1] ^ b_v[1];
      rc1 <= a_v[1] & b_v[1];
   end

   // Adder models: 0 good, 1 carry stuck 0, 2 sum inverted, 3 registered
   always_comb begin
      sum0   = a_v[0] ^ b_v[0];
      carry0 = a_v[0] & b_v[0];
      case (mode0)
         2'd1: carry0 = 1'b0;
         2'd2: sum0 = ~(a_v[0] ^ b_v[0]);
         2'd3: begin sum0 = rs0; carry0 = rc0; end
         default: ;
      endcase
      sum1   = rs1;
      carry1 = rc1;
      sum2   = ~(a_v[2] ^ b_v[2]);
      carry2 = ~(a_v[2] & b_v[2]);
   end

   // Start one run, record the vector stream and busy length; returns with done sampled
   task automatic do_run(input int inst, output int nbusy, output logic [15:0] vecs, output logic done_seen);
      start_v[inst] = 1'b1;
      @(posedge clk); #1;
      start_v[inst] = 1'b0;
      nbusy = 0;
      vecs = '0;
      while (busy_v[inst] === 1'b1 && nbusy < 64) begin
         vecs = {vecs[13:0], a_v[inst], b_v[inst]};
         nbusy++;
         @(posedge clk); #1;
      end
      done_seen = done_v[inst];
   endtask

   task automatic test_reset();
      logic [15:0] o;
      o = {busy_v[0], done_v[0], pass_v[0], fv_v[0], a_v[0], b_v[0], fvec0, err0};
      n_total++;
      if (o !== 16'h0) $display("FAIL reset_u0 got=%h exp=0000", o); else n_pass++;
      o = {busy_v[1], done_v[1], pass_v[1], fv_v[1], a_v[1], b_v[1], fvec1, err1};
      n_total++;
      if (o !== 16'h0) $display("FAIL reset_u1 got=%h exp=0000", o); else n_pass++;
      o = {6'd0, busy_v[2], done_v[2], pass_v[2], fv_v[2], a_v[2], b_v[2], fvec2, err2};
      n_total++;
      if (o !== 16'h0) $display("FAIL reset_u2 got=%h exp=0000", o); else n_pass++;
   endtask

   task automatic test_clean();
      int nb; logic [15:0] v; logic d;
      mode0 = 2'd0;
      do_run(0, nb, v, d);
      n_total++; if (nb !== 4) $display("FAIL clean_busy got=%0d exp=4", nb); else n_pass++;
      n_total++; if (v[7:0] !== 8'h1B) $display("FAIL clean_vecs got=%h exp=1b", v[7:0]); else n_pass++;
      n_total++; if (d !== 1'b1) $display("FAIL clean_done got=%b exp=1", d); else n_pass++;
      n_total++; if (pass_v[0] !== 1'b1) $display("FAIL clean_pass got=%b exp=1", pass_v[0]); else n_pass++;
      n_total++; if (err0 !== 8'd0) $display("FAIL clean_err got=%0d exp=0", err0); else n_pass++;
      n_total++; if (fv_v[0] !== 1'b0) $display("FAIL clean_fv got=%b exp=0", fv_v[0]); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (done_v[0] !== 1'b0) $display("FAIL clean_done_pulse got=%b exp=0", done_v[0]); else n_pass++;
      n_total++; if (pass_v[0] !== 1'b1) $display("FAIL clean_pass_hold got=%b exp=1", pass_v[0]); else n_pass++;
   endtask

   task automatic test_carry_stuck();
      int nb; logic [15:0] v; logic d;
      mode0 = 2'd1;
      do_run(0, nb, v, d);
      n_total++; if (err0 !== 8'd1) $display("FAIL stuck_err got=%0d exp=1", err0); else n_pass++;
      n_total++; if (fv_v[0] !== 1'b1) $display("FAIL stuck_fv got=%b exp=1", fv_v[0]); else n_pass++;
      n_total++; if (fvec0 !== 2'b11) $display("FAIL stuck_fvec got=%b exp=11", fvec0); else n_pass++;
      n_total++; if (pass_v[0] !== 1'b0) $display("FAIL stuck_pass got=%b exp=0", pass_v[0]); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_sum_inverted();
      int nb; logic [15:0] v; logic d;
      mode0 = 2'd2;
      do_run(0, nb, v, d);
      n_total++; if (err0 !== 8'd4) $display("FAIL suminv_err got=%0d exp=4", err0); else n_pass++;
      n_total++; if (fvec0 !== 2'b00) $display("FAIL suminv_fvec got=%b exp=00", fvec0); else n_pass++;
      n_total++; if (pass_v[0] !== 1'b0) $display("FAIL suminv_pass got=%b exp=0", pass_v[0]); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      int nb; logic [15:0] v; logic d;
      do_run(1, nb, v, d);
      n_total++; if (nb !== 8) $display("FAIL lat1_busy got=%0d exp=8", nb); else n_pass++;
      n_total++; if (v !== 16'h05AF) $display("FAIL lat1_vecs got=%h exp=05af", v); else n_pass++;
      n_total++; if (d !== 1'b1) $display("FAIL lat1_done got=%b exp=1", d); else n_pass++;
      n_total++; if (pass_v[1] !== 1'b1) $display("FAIL lat1_pass got=%b exp=1", pass_v[1]); else n_pass++;
      n_total++; if (err1 !== 8'd0) $display("FAIL lat1_err got=%0d exp=0", err1); else n_pass++;
      @(posedge clk); #1;
      // Registered adder checked with zero latency sees the previous vector's response
      mode0 = 2'd3;
      do_run(0, nb, v, d);
      n_total++; if (pass_v[0] !== 1'b0) $display("FAIL lat0_pass got=%b exp=0", pass_v[0]); else n_pass++;
      n_total++; if (err0 !== 8'd2) $display("FAIL lat0_err got=%0d exp=2", err0); else n_pass++;
      n_total++; if (fvec0 !== 2'b01) $display("FAIL lat0_fvec got=%b exp=01", fvec0); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_saturate();
      int nb; logic [15:0] v; logic d;
      do_run(2, nb, v, d);
      n_total++; if (nb !== 8) $display("FAIL sat_busy got=%0d exp=8", nb); else n_pass++;
      n_total++; if (v !== 16'h1B1B) $display("FAIL sat_vecs got=%h exp=1b1b", v); else n_pass++;
      n_total++; if (err2 !== 2'd3) $display("FAIL sat_err got=%0d exp=3", err2); else n_pass++;
      n_total++; if (fvec2 !== 2'b00) $display("FAIL sat_fvec got=%b exp=00", fvec2); else n_pass++;
      n_total++; if (fv_v[2] !== 1'b1) $display("FAIL sat_fv got=%b exp=1", fv_v[2]); else n_pass++;
      n_total++; if (pass_v[2] !== 1'b0) $display("FAIL sat_pass got=%b exp=0", pass_v[2]); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midrun();
      logic [15:0] o;
      int ndone;
      mode0 = 2'd2;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      o = {busy_v[0], done_v[0], pass_v[0], fv_v[0], a_v[0], b_v[0], fvec0, err0};
      n_total++;
      if (o !== 16'h0) $display("FAIL midrst_outputs got=%h exp=0000", o); else n_pass++;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) ndone++;
      end
      n_total++;
      if (ndone !== 0) $display("FAIL midrst_no_done got=%0d exp=0", ndone); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int nb; logic [15:0] v; logic d;
      mode0 = 2'd0;
      // start pulsed mid-run must not extend or restart the run
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      @(posedge clk); #1;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      nb = 2;
      while (busy_v[0] === 1'b1 && nb < 64) begin
         nb++;
         @(posedge clk); #1;
      end
      n_total++; if (nb !== 4) $display("FAIL busystart_len got=%0d exp=4", nb); else n_pass++;
      n_total++; if (done_v[0] !== 1'b1) $display("FAIL busystart_done got=%b exp=1", done_v[0]); else n_pass++;
      // start during DONE must also be ignored
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      n_total++; if (busy_v[0] !== 1'b0) $display("FAIL donestart_busy got=%b exp=0", busy_v[0]); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (busy_v[0] !== 1'b0) $display("FAIL idle_stays got=%b exp=0", busy_v[0]); else n_pass++;
      do_run(0, nb, v, d);
      n_total++; if (nb !== 4) $display("FAIL rerun_busy got=%0d exp=4", nb); else n_pass++;
      n_total++; if (v[7:0] !== 8'h1B) $display("FAIL rerun_vecs got=%h exp=1b", v[7:0]); else n_pass++;
      n_total++; if (pass_v[0] !== 1'b1) $display("FAIL rerun_pass got=%b exp=1", pass_v[0]); else n_pass++;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      start_v = 3'b000;
      mode0 = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_clean();
      test_carry_stuck();
      test_sum_inverted();
      test_latency();
      test_saturate();
      test_reset_midrun();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
